// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack burst controller: request opcodes and FSM state encoding.
package stack_ctrl_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH      = 3'd1,
        ST_POP_ISSUE = 3'd2,
        ST_POP_CAPT  = 3'd3,
        ST_POP_HOLD  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/stack_burst_ctrl.sv
// Serialises burst push/pop requests into single-cycle stack enables and returns
// popped words over a valid/ready channel, reporting completion count and error.
module stack_burst_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SP_W   = 17,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [CNT_W-1:0]  req_count,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              done_err,
    output logic [CNT_W-1:0]  done_count,
    output logic              busy,
    output logic [SP_W-1:0]   cur_sp,
    output logic              push_enable,
    output logic              pop_enable,
    output logic [DATA_W-1:0] stack_data_in,
    input  logic [DATA_W-1:0] stack_data_out,
    input  logic [SP_W-1:0]   stack_sp,
    input  logic              stack_full,
    input  logic              stack_empty,
    input  logic              stack_valid_out
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic             err;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_now;

    assign cnt_inc = cnt + CNT_W'(1);
    assign err_now = err | stack_valid_out;

    assign req_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign push_enable   = (state == ST_PUSH) && wdata_valid && !stack_full;
    assign wdata_ready   = push_enable;
    // Only POP_ISSUE can pop, and it always leaves after one cycle, so the pulse is single-cycle.
    assign pop_enable    = (state == ST_POP_ISSUE) && !stack_empty;
    assign stack_data_in = wdata;
    assign cur_sp        = stack_sp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            target      <= '0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            done_err    <= 1'b0;
            done_count  <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && state != ST_DONE && stack_valid_out)
                err <= 1'b1;

            // done/done_count/done_err are loaded on entry to DONE so they are valid during it.
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        target <= req_count;
                        cnt    <= '0;
                        err    <= 1'b0;
                        if (req_count == '0) begin
                            err        <= 1'b1;
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            done_count <= '0;
                            done_err   <= 1'b1;
                        end else if (req_op == OP_POP) begin
                            state <= ST_POP_ISSUE;
                        end else begin
                            state <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (push_enable) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == target) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            done_count <= cnt_inc;
                            done_err   <= err_now;
                        end
                    end else if (stack_full) begin
                        err        <= 1'b1;
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        done_count <= cnt;
                        done_err   <= 1'b1;
                    end
                end
                ST_POP_ISSUE: begin
                    if (stack_empty) begin
                        err        <= 1'b1;
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        done_count <= cnt;
                        done_err   <= 1'b1;
                    end else begin
                        state <= ST_POP_CAPT;
                    end
                end
                ST_POP_CAPT: begin
                    rdata       <= stack_data_out;
                    rdata_valid <= 1'b1;
                    state       <= ST_POP_HOLD;
                end
                ST_POP_HOLD: begin
                    if (rdata_valid && rdata_ready) begin
                        rdata_valid <= 1'b0;
                        cnt         <= cnt_inc;
                        if (cnt_inc == target) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            done_count <= cnt_inc;
                            done_err   <= err_now;
                        end else begin
                            state <= ST_POP_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_burst_ctrl.sv
// Directed bench for stack_burst_ctrl with a small behavioural stack attached.
module tb_stack_burst_ctrl;
    import stack_ctrl_pkg::*;

    localparam int DATA_W = 32;
    localparam int SP_W   = 17;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_op = 1'b0;
    logic [CNT_W-1:0]  req_count = '0;
    logic              wdata_valid = 1'b0;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata = '0;
    logic              rdata_valid;
    logic              rdata_ready = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              done_err;
    logic [CNT_W-1:0]  done_count;
    logic              busy;
    logic [SP_W-1:0]   cur_sp;
    logic              push_enable;
    logic              pop_enable;
    logic [DATA_W-1:0] stack_data_in;
    logic [DATA_W-1:0] stack_data_out = '0;
    logic [SP_W-1:0]   stack_sp;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_valid_out = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural stack: 16 words, byte-addressed sp growing downward by 4 per push.
    logic [DATA_W-1:0] mem [0:15];
    int   depth = 0;
    logic force_full = 1'b0;
    int   n_push = 0;
    int   n_pop  = 0;
    int   n_done = 0;
    bit   both_hi = 1'b0;

    assign stack_full  = (depth == 16) || force_full;
    assign stack_empty = (depth == 0);
    assign stack_sp    = 17'h10000 - SP_W'(depth * 4);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (push_enable && depth < 16) begin
            mem[depth] <= stack_data_in;
            depth      <= depth + 1;
        end else if (pop_enable && depth > 0) begin
            stack_data_out <= mem[depth-1];
            depth          <= depth - 1;
        end
        if (push_enable) n_push <= n_push + 1;
        if (pop_enable)  n_pop  <= n_pop + 1;
        if (done)        n_done <= n_done + 1;
        if (push_enable && pop_enable) both_hi <= 1'b1;
    end

    stack_burst_ctrl #(.DATA_W(DATA_W), .SP_W(SP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_count(req_count),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .done_err(done_err), .done_count(done_count), .busy(busy),
        .cur_sp(cur_sp), .push_enable(push_enable), .pop_enable(pop_enable),
        .stack_data_in(stack_data_in), .stack_data_out(stack_data_out),
        .stack_sp(stack_sp), .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_valid_out(stack_valid_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic op, input logic [CNT_W-1:0] c);
        req_op    = op;
        req_count = c;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic [CNT_W-1:0] cv, output logic ev);
        bit got = 1'b0;
        cv = '0;
        ev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                cv  = done_count;
                ev  = done_err;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, output int stalls);
        wdata       = d;
        wdata_valid = 1'b1;
        stalls      = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wdata_ready) break;
            stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pop_word(input string tag, output logic [DATA_W-1:0] d);
        bit got = 1'b0;
        rdata_ready = 1'b1;
        d = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdata_valid) begin
                got = 1'b1;
                d   = rdata;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_rdata_valid expected=rdata_valid", tag);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0]  dc;
        logic              de;
        logic [DATA_W-1:0] d;
        logic [SP_W-1:0]   sp0;
        int s0, s1, s2, p0, dn;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_push_en", push_enable, 0);
        chk("rst_pop_en", pop_enable, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_rdata", rdata, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: push burst of three
        sp0 = cur_sp;
        p0  = n_push;
        issue(OP_PUSH, 4'd3);
        chk("push_busy", busy, 1);
        push_word(32'hA, s0);
        push_word(32'hB, s1);
        push_word(32'hC, s2);
        wdata_valid = 1'b0;
        chk("push_stalls", s0 + s1 + s2, 0);
        wait_done("push3", dc, de);
        chk("push3_count", dc, 3);
        chk("push3_err", de, 0);
        chk("push3_pulses", n_push - p0, 3);
        chk("push3_sp_drop", sp0 - cur_sp, 12);

        // 3: pop burst of two
        p0 = n_pop;
        issue(OP_POP, 4'd2);
        pop_word("pop_w0", d);
        chk("pop_w0", d, 32'hC);
        pop_word("pop_w1", d);
        chk("pop_w1", d, 32'hB);
        rdata_ready = 1'b0;
        wait_done("pop2", dc, de);
        chk("pop2_count", dc, 2);
        chk("pop2_err", de, 0);
        chk("pop2_pulses", n_pop - p0, 2);

        // 4: drain the last word, then underflow
        issue(OP_POP, 4'd1);
        pop_word("pop_last", d);
        chk("pop_last", d, 32'hA);
        rdata_ready = 1'b0;
        wait_done("pop1", dc, de);
        chk("pop1_err", de, 0);
        p0 = n_pop;
        issue(OP_POP, 4'd1);
        wait_done("under", dc, de);
        chk("under_err", de, 1);
        chk("under_count", dc, 0);
        chk("under_pulses", n_pop - p0, 0);

        // zero-length request is illegal
        p0 = n_push;
        issue(OP_PUSH, 4'd0);
        wait_done("zero", dc, de);
        chk("zero_err", de, 1);
        chk("zero_count", dc, 0);
        chk("zero_pulses", n_push - p0, 0);

        // 5: overflow after the first word
        p0 = n_push;
        issue(OP_PUSH, 4'd4);
        push_word(32'h11, s0);
        force_full = 1'b1;
        wdata      = 32'h22;
        @(negedge clk);
        chk("ovf_wready", wdata_ready, 0);
        wait_done("ovf", dc, de);
        chk("ovf_err", de, 1);
        chk("ovf_count", dc, 1);
        chk("ovf_wready_after", wdata_ready, 0);
        chk("ovf_pulses", n_push - p0, 1);
        force_full  = 1'b0;
        wdata_valid = 1'b0;

        // 6: backpressure then reset mid-burst
        issue(OP_PUSH, 4'd1);
        push_word(32'h22, s0);
        wdata_valid = 1'b0;
        wait_done("push1", dc, de);
        rdata_ready = 1'b0;
        p0 = n_pop;
        issue(OP_POP, 4'd2);
        s0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdata_valid) break;
            s0++;
        end
        chk("bp_first", rdata, 32'h22);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_data", rdata, 32'h22);
            chk("bp_hold_valid", rdata_valid, 1);
        end
        chk("bp_pulses", n_pop - p0, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_push_en", push_enable, 0);
        chk("mid_rst_pop_en", pop_enable, 0);
        chk("mid_rst_rvalid", rdata_valid, 0);
        dn = n_done;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_done", n_done - dn, 0);
        chk("mid_rst_idle", busy, 0);
        chk("never_both_enables", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
